// File: rtl/aes128_sched_pkg.sv
// Shared types and helpers for the AES-128 job scheduler.
package aes128_sched_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } sched_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/aes128_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at/after the pointer wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    cand  = ptr_i;
    found = 1'b0;
    idx_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
      cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
    end
    any_o = found;
    gnt_o = found ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/aes128_job_scheduler.sv
// Shares one AES-128 core among NUM_REQ requesters; one job in flight, result
// captured after a fixed latency and returned on a valid/ready response port.
module aes128_job_scheduler
  import aes128_sched_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int CORE_LATENCY = 44,
  parameter  int START_CYCLES = 1,
  localparam int ID_W         = clog2(NUM_REQ)
) (
  input  logic                           pi_clk,
  input  logic                           pi_rst,
  input  logic [NUM_REQ-1:0]             pi_req_valid,
  input  logic [NUM_REQ*AES_BLOCK_W-1:0] pi_req_key,
  input  logic [NUM_REQ*AES_BLOCK_W-1:0] pi_req_data,
  output logic [NUM_REQ-1:0]             po_req_ready,
  output logic [AES_BLOCK_W-1:0]         po_core_key,
  output logic [AES_BLOCK_W-1:0]         po_core_data,
  output logic                           po_core_start,
  input  logic [AES_BLOCK_W-1:0]         pi_core_result,
  output logic                           po_rsp_valid,
  output logic [AES_BLOCK_W-1:0]         po_rsp_data,
  output logic [ID_W-1:0]                po_rsp_id,
  input  logic                           pi_rsp_ready,
  output logic                           po_busy
);

  localparam int CNT_W = clog2(CORE_LATENCY + 1);

  sched_state_e           state_q;
  logic [ID_W-1:0]        ptr_q;
  logic [ID_W-1:0]        ptr_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [AES_BLOCK_W-1:0] key_q;
  logic [AES_BLOCK_W-1:0] data_q;
  logic [ID_W-1:0]        id_q;
  logic                   start_q;
  logic                   rsp_valid_q;
  logic [AES_BLOCK_W-1:0] rsp_data_q;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [ID_W-1:0]        arb_idx;
  logic                   arb_any;
  logic [AES_BLOCK_W-1:0] key_arr  [NUM_REQ];
  logic [AES_BLOCK_W-1:0] data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign key_arr[gi]  = pi_req_key[gi*AES_BLOCK_W +: AES_BLOCK_W];
    assign data_arr[gi] = pi_req_data[gi*AES_BLOCK_W +: AES_BLOCK_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i (pi_req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign ptr_d = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

  // Counter value 1 marks the first start cycle; capture happens when it reaches CORE_LATENCY.
  always_ff @(posedge pi_clk or negedge pi_rst) begin
    if (!pi_rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      key_q       <= '0;
      data_q      <= '0;
      id_q        <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            key_q   <= key_arr[arb_idx];
            data_q  <= data_arr[arb_idx];
            id_q    <= arb_idx;
            ptr_q   <= ptr_d;
            cnt_q   <= CNT_W'(1);
            start_q <= 1'b1;
            state_q <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(START_CYCLES)) begin
            start_q <= 1'b0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == CNT_W'(CORE_LATENCY)) begin
            rsp_data_q  <= pi_core_result;
            rsp_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (pi_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign po_req_ready  = (state_q == ST_IDLE) ? arb_gnt : '0;
  assign po_core_key   = key_q;
  assign po_core_data  = data_q;
  assign po_core_start = start_q;
  assign po_rsp_valid  = rsp_valid_q;
  assign po_rsp_data   = rsp_data_q;
  assign po_rsp_id     = id_q;
  assign po_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes128_job_scheduler.sv
// Scoreboard bench for the AES-128 job scheduler with a behavioural fixed-latency core model.
module tb_aes128_job_scheduler;

  localparam int LAT_A = 44;
  localparam int LAT_B = 10;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] GARB     = 128'hdeadbeef_0badf00d_cafebabe_55aa55aa;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic pi_rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: 4 requesters, latency 44, 1 start cycle
  logic [3:0]   req_valid;
  logic [511:0] req_key, req_data;
  logic [3:0]   req_ready;
  logic [127:0] core_key, core_data, core_result, rsp_data;
  logic         core_start, rsp_valid, rsp_ready, busy;
  logic [1:0]   rsp_id;

  // instance B: 2 requesters, latency 10, 3 start cycles
  logic [1:0]   b_req_valid;
  logic [255:0] b_key, b_data;
  logic [1:0]   b_req_ready;
  logic [127:0] b_core_key, b_core_data, b_core_result, b_rsp_data;
  logic         b_start, b_rsp_valid, b_rsp_ready, b_busy;
  logic [0:0]   b_rsp_id;

  aes128_job_scheduler #(.NUM_REQ(4), .CORE_LATENCY(LAT_A), .START_CYCLES(1)) u_dut (
    .pi_clk(clk), .pi_rst(pi_rst), .pi_req_valid(req_valid), .pi_req_key(req_key),
    .pi_req_data(req_data), .po_req_ready(req_ready), .po_core_key(core_key),
    .po_core_data(core_data), .po_core_start(core_start), .pi_core_result(core_result),
    .po_rsp_valid(rsp_valid), .po_rsp_data(rsp_data), .po_rsp_id(rsp_id),
    .pi_rsp_ready(rsp_ready), .po_busy(busy)
  );

  aes128_job_scheduler #(.NUM_REQ(2), .CORE_LATENCY(LAT_B), .START_CYCLES(3)) u_dut_b (
    .pi_clk(clk), .pi_rst(pi_rst), .pi_req_valid(b_req_valid), .pi_req_key(b_key),
    .pi_req_data(b_data), .po_req_ready(b_req_ready), .po_core_key(b_core_key),
    .po_core_data(b_core_data), .po_core_start(b_start), .pi_core_result(b_core_result),
    .po_rsp_valid(b_rsp_valid), .po_rsp_data(b_rsp_data), .po_rsp_id(b_rsp_id),
    .pi_rsp_ready(b_rsp_ready), .po_busy(b_busy)
  );

  // Behavioural cipher: the FIPS-197 vector exactly, an arbitrary mixing function otherwise.
  function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] d);
    if (k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
    return {k[63:0] ^ d[127:64], k[127:64] + d[63:0]} ^ 128'h5a5a_5a5a_0123_4567_89ab_cdef_a5a5_a5a5;
  endfunction

  // Core models: mc is the index of the current cycle counting the first start cycle as 1.
  int mc_a, mc_b;
  logic [127:0] jk_a, jd_a, jk_b, jd_b;
  always @(posedge clk or negedge pi_rst) begin
    if (!pi_rst) begin
      mc_a <= 0;
    end else if (core_start && (mc_a == 0 || mc_a > LAT_A)) begin
      mc_a <= 2; jk_a <= core_key; jd_a <= core_data;
    end else if (mc_a != 0 && mc_a <= LAT_A) begin
      mc_a <= mc_a + 1;
    end
  end
  always @(posedge clk or negedge pi_rst) begin
    if (!pi_rst) begin
      mc_b <= 0;
    end else if (b_start && (mc_b == 0 || mc_b > LAT_B)) begin
      mc_b <= 2; jk_b <= b_core_key; jd_b <= b_core_data;
    end else if (mc_b != 0 && mc_b <= LAT_B) begin
      mc_b <= mc_b + 1;
    end
  end
  assign core_result   = (mc_a == LAT_A) ? core_f(jk_a, jd_a) : (GARB ^ {4{cyc}});
  assign b_core_result = (mc_b == LAT_B) ? core_f(jk_b, jd_b) : (GARB ^ {4{cyc}});

  typedef struct { int id; logic [127:0] data; } exp_t;
  exp_t         sb[$];
  int           gnt_log[$];
  int           gnt_cyc[$];
  int           rsp_rise[$];
  logic [127:0] rsp_seen[$];
  int           n_rsp = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  logic         prev_rv = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor for instance A: push at grant, pop and compare at response accept.
  always @(negedge clk) begin
    if (pi_rst) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{id: i, data: core_f(req_key[i*128 +: 128], req_data[i*128 +: 128])});
          gnt_log.push_back(i);
          gnt_cyc.push_back(cyc + 1);
          $display("grant id=%0d at cycle %0d", i, cyc + 1);
        end
      end
      if (rsp_valid && !prev_rv) rsp_rise.push_back(cyc);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 128'd1, 128'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id", 128'(rsp_id), 128'(e.id));
          chk("rsp_data", rsp_data, e.data);
        end
        rsp_seen.push_back(rsp_data);
        n_rsp <= n_rsp + 1;
        $display("response id=%0d data=%h at cycle %0d", rsp_id, rsp_data, cyc);
      end
    end
    prev_rv <= rsp_valid;
  end

  task automatic wait_busy(input string tag);
    for (int k = 0; k < 100 && !busy; k++) begin
      @(posedge clk); #1;
    end
    chk(tag, 128'(busy), 128'd1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int k = 0; k < budget && (sb.size() != 0 || busy); k++) begin
      @(posedge clk); #1;
    end
    chk(tag, 128'(sb.size()), 128'd0);
  endtask

  initial begin
    int stale, g, starts, first, last, rise;
    req_valid = '0; req_key = '0; req_data = '0; rsp_ready = 1'b0;
    b_req_valid = '0; b_key = '0; b_data = '0; b_rsp_ready = 1'b0;
    pi_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 128'(req_ready), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_start", 128'(core_start), 128'd0);
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_rsp_data", rsp_data, 128'd0);
    chk("rst_core_key", core_key, 128'd0);

    // all four requesters pending from reset, req0 carries the FIPS-197 vector
    req_key  = {128'h33, 128'h22, 128'h11, FIPS_KEY};
    req_data = {128'h3333, 128'h2222, 128'h1111, FIPS_PT};
    req_valid = 4'hf;
    rsp_ready = 1'b1;
    pi_rst = 1'b1;
    for (int k = 0; k < 400 && n_rsp < 5; k++) begin
      @(posedge clk); #1;
    end
    req_valid = '0;
    chk("t2_five_rsp", 128'(n_rsp), 128'd5);
    for (int i = 0; i < 5; i++)
      chk("t2_gnt_order", 128'(i < gnt_log.size() ? gnt_log[i] : -1), 128'(i % 4));
    if (rsp_seen.size() > 0) chk("t1_fips_ct", rsp_seen[0], FIPS_CT);
    else chk("t1_fips_missing", 128'd0, 128'd1);
    if (rsp_rise.size() > 0 && gnt_cyc.size() > 1) begin
      chk("t1_latency", 128'(rsp_rise[0] - gnt_cyc[0]), 128'(LAT_A));
      chk("t2_gnt_spacing", 128'(gnt_cyc[1] - gnt_cyc[0]), 128'(LAT_A + 2));
    end else begin
      chk("t1_timing_missing", 128'd0, 128'd1);
    end
    wait_drain("t2_drain", 10);

    // backpressure: response held 20 cycles with another request pending
    rsp_ready = 1'b0;
    req_key[255:128] = 128'hfeed_0001; req_data[255:128] = 128'hc0de_0001;
    req_valid = 4'b0010;
    wait_busy("t3_grant");
    req_valid = '0;
    for (int k = 0; k < 80 && !rsp_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("t3_rsp_valid", 128'(rsp_valid), 128'd1);
    req_valid = 4'b1000;
    repeat (20) begin
      @(negedge clk);
      chk("t3_hold_data", rsp_data, sb.size() > 0 ? sb[0].data : 128'd0);
      chk("t3_hold_id", 128'(rsp_id), 128'd1);
      chk("t3_hold_valid", 128'(rsp_valid), 128'd1);
      chk("t3_no_grant", 128'(req_ready), 128'd0);
      chk("t3_no_start", 128'(core_start), 128'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = '0;
    wait_drain("t3_drain", 10);

    // requester 2 changes its inputs right after the grant edge
    req_key[383:256] = 128'h1234_5678_9abc_def0; req_data[383:256] = 128'h0fed_cba9_8765_4321;
    req_valid = 4'b0100;
    wait_busy("t4_grant");
    chk("t4_start_on", 128'(core_start), 128'd1);
    req_key[383:256] = 128'h0; req_data[383:256] = 128'hffff;
    req_valid = '0;
    chk("t4_core_key", core_key, 128'h1234_5678_9abc_def0);
    chk("t4_core_data", core_data, 128'h0fed_cba9_8765_4321);
    @(posedge clk); #1;
    chk("t4_start_len", 128'(core_start), 128'd0);
    chk("t4_core_key_hold", core_key, 128'h1234_5678_9abc_def0);
    wait_drain("t4_drain", 100);

    // reset asserted mid-job, between clock edges
    req_key[127:0] = 128'h5555; req_data[127:0] = 128'h6666;
    req_valid = 4'b0001;
    wait_busy("t5_grant");
    req_valid = '0;
    repeat (10) @(posedge clk);
    #3;
    pi_rst = 1'b0;
    #1;
    chk("t5_busy", 128'(busy), 128'd0);
    chk("t5_start", 128'(core_start), 128'd0);
    chk("t5_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("t5_core_key", core_key, 128'd0);
    chk("t5_core_data", core_data, 128'd0);
    chk("t5_rsp_id", 128'(rsp_id), 128'd0);
    sb.delete();
    @(posedge clk); #1;
    pi_rst = 1'b1;
    stale = 0;
    repeat (60) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    chk("t5_no_stale", 128'(stale), 128'd0);
    req_key[511:384] = 128'habcd_ef01; req_data[511:384] = 128'h2345_6789;
    req_valid = 4'b1000;
    wait_busy("t5_regrant");
    req_valid = '0;
    wait_drain("t5_drain", 100);

    // instance B: three start cycles, capture still CORE_LATENCY after first start
    b_key = {128'h0, 128'h7777_0000_1111}; b_data = {128'h0, 128'h8888_2222};
    b_req_valid = 2'b01;
    b_rsp_ready = 1'b1;
    for (int k = 0; k < 20 && !b_busy; k++) begin
      @(posedge clk); #1;
    end
    chk("t6_grant", 128'(b_busy), 128'd1);
    g = cyc;
    b_req_valid = '0;
    starts = 0; first = -1; last = -1; rise = -1;
    for (int k = 0; k < 40 && rise < 0; k++) begin
      @(negedge clk);
      if (b_start) begin
        if (first < 0) first = cyc;
        last = cyc;
        starts++;
      end
      if (b_rsp_valid) rise = cyc;
    end
    chk("t6_start_cycles", 128'(starts), 128'd3);
    chk("t6_start_first", 128'(first), 128'(g));
    chk("t6_start_last", 128'(last), 128'(g + 2));
    chk("t6_latency", 128'(rise), 128'(g + LAT_B));
    chk("t6_rsp_data", b_rsp_data, core_f(128'h7777_0000_1111, 128'h8888_2222));
    chk("t6_rsp_id", 128'(b_rsp_id), 128'd0);
    $display("response B id=%0d data=%h at cycle %0d", b_rsp_id, b_rsp_data, rise);
    @(posedge clk); #1;
    chk("t6_accept", 128'(b_rsp_valid), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
